// File: rtl/dsm_dem_ctrl_pkg.sv
// Shared types for the sigma-delta sample scheduler: FSM encoding, PCM pair layout, counter helpers.
// Latency: n/a (types only). Backpressure: n/a.
package dsm_dem_ctrl_pkg;

  localparam int PCM_W      = 24;
  localparam int DEM_W      = 2;
  localparam int OVFL_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2,
    MUTE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [PCM_W-1:0] left;
    logic [PCM_W-1:0] right;
  } pcm_pair_t;

  function automatic logic [OVFL_CNT_W-1:0] sat_inc(input logic [OVFL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dsm_dem_ctrl_fifo.sv
// Small synchronous FIFO of stereo PCM pairs; read data is the head entry (no bypass).
// Latency: 1 cycle push-to-visible. Backpressure: full blocks push, pop on empty is ignored, flush wins.
module dsm_dem_ctrl_fifo
  import dsm_dem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  pcm_pair_t wr_dat,
  output pcm_pair_t rd_dat,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  pcm_pair_t     mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          wr_en;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_dat = mem[rd_ptr[AW-1:0]];
  assign wr_en  = push && !full && !flush;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dsm_dem_ctrl.sv
// Frame scheduler/supervisor for the dual-channel DEM modulator; optional DSM_DEM_SOFTSTART_EN ramps output after recovery.
// Latency: popped sample appears on dsm_chan the cycle after frame_tick. Backpressure: s_ready drops when FIFO full or IDLE.
module dsm_dem_ctrl
  import dsm_dem_ctrl_pkg::*;
#(
  parameter int unsigned FRAME_LEN   = 512,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned CLR_CYCLES  = 4,
  parameter int unsigned MUTE_FRAMES = 8
) (
  input  logic                  mclk512,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [PCM_W-1:0]      s_left,
  input  logic [PCM_W-1:0]      s_right,
  input  logic                  cfg_exchange_lr,
  input  logic                  cfg_dither_off,
  input  logic [DEM_W-1:0]      cfg_dem_count,
  input  logic                  dsm_ovfl,
  output logic [PCM_W-1:0]      dsm_chan1,
  output logic [PCM_W-1:0]      dsm_chan2,
  output logic                  dsm_clr,
  output logic                  dsmditheroff,
  output logic [DEM_W-1:0]      dem_count,
  output logic                  frame_tick,
  output logic                  underrun,
  input  logic                  underrun_clr,
  output logic [OVFL_CNT_W-1:0] ovfl_count,
  output logic [1:0]            state
);

  localparam int FCW = $clog2(FRAME_LEN);
  localparam int CCW = $clog2(CLR_CYCLES + 1);
  localparam int MCW = $clog2(MUTE_FRAMES + 1);
  localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAME_LEN - 1);
  localparam logic [CCW-1:0] CLR_LAST   = CCW'(CLR_CYCLES - 1);
  localparam logic [MCW-1:0] MUTE_LAST  = MCW'(MUTE_FRAMES - 1);

  state_t          st;
  state_t          st_nxt;
  logic [FCW-1:0]  frame_cnt;
  logic [CCW-1:0]  clr_cnt;
  logic [MCW-1:0]  mute_cnt;

  pcm_pair_t       fifo_in;
  pcm_pair_t       fifo_head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push_vld;
  logic            run_pop;
  logic [PCM_W-1:0] sel1;
  logic [PCM_W-1:0] sel2;
  logic [PCM_W-1:0] out1;
  logic [PCM_W-1:0] out2;

  assign state      = st;
  assign frame_tick = (st != IDLE) && (frame_cnt == FRAME_LAST);
  assign dsm_clr    = (st == IDLE) || (st == CLEAR);
  assign s_ready    = !fifo_full && (st != IDLE);
  assign push_vld   = s_valid && s_ready;
  assign fifo_in    = '{left: s_left, right: s_right};

  dsm_dem_ctrl_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (mclk512),
    .reset  (reset),
    .push   (push_vld),
    .pop    (frame_tick),
    .flush  (!enable),
    .wr_dat (fifo_in),
    .rd_dat (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge mclk512) begin
    if (reset) begin
      st <= IDLE;
    end else begin
      st <= st_nxt;
    end
  end

  always_comb begin
    st_nxt = st;
    if (!enable) begin
      st_nxt = IDLE;
    end else begin
      case (st)
        IDLE:    st_nxt = RUN;
        RUN:     if (dsm_ovfl) st_nxt = CLEAR;
        CLEAR:   if (clr_cnt == CLR_LAST) st_nxt = MUTE;
        MUTE:    if (frame_tick && (mute_cnt == MUTE_LAST)) st_nxt = RUN;
        default: st_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge mclk512) begin
    if (reset) begin
      frame_cnt <= '0;
      clr_cnt   <= '0;
      mute_cnt  <= '0;
    end else begin
      if ((st == IDLE) || (st_nxt == IDLE) || (frame_cnt == FRAME_LAST)) begin
        frame_cnt <= '0;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
      clr_cnt  <= (st == CLEAR) ? clr_cnt + 1'b1 : '0;
      mute_cnt <= (st != MUTE) ? '0 : (frame_tick ? mute_cnt + 1'b1 : mute_cnt);
    end
  end

  assign run_pop = (st == RUN) && frame_tick && !fifo_empty && !dsm_ovfl;
  assign sel1    = cfg_exchange_lr ? fifo_head.right : fifo_head.left;
  assign sel2    = cfg_exchange_lr ? fifo_head.left  : fifo_head.right;

`ifdef DSM_DEM_SOFTSTART_EN
  logic [2:0] soft_shift;

  // Each recovery restarts the ramp at /128 and halves the attenuation per sample.
  always_ff @(posedge mclk512) begin
    if (reset) begin
      soft_shift <= '0;
    end else if ((st == MUTE) && (st_nxt == RUN)) begin
      soft_shift <= 3'd7;
    end else if (enable && run_pop && (soft_shift != 3'd0)) begin
      soft_shift <= soft_shift - 3'd1;
    end
  end

  assign out1 = $signed(sel1) >>> soft_shift;
  assign out2 = $signed(sel2) >>> soft_shift;
`else
  assign out1 = sel1;
  assign out2 = sel2;
`endif

  always_ff @(posedge mclk512) begin
    if (reset) begin
      dsm_chan1    <= '0;
      dsm_chan2    <= '0;
      dsmditheroff <= 1'b0;
      dem_count    <= '0;
      ovfl_count   <= '0;
      underrun     <= 1'b0;
    end else begin
      if (!enable) begin
        dsm_chan1    <= '0;
        dsm_chan2    <= '0;
        dsmditheroff <= 1'b0;
        dem_count    <= '0;
      end else begin
        // Config only moves on frame boundaries so the modulator never sees a mid-frame change.
        if (frame_tick) begin
          dsmditheroff <= cfg_dither_off;
          dem_count    <= cfg_dem_count;
        end
        if ((st != RUN) || dsm_ovfl) begin
          dsm_chan1 <= '0;
          dsm_chan2 <= '0;
        end else if (run_pop) begin
          dsm_chan1 <= out1;
          dsm_chan2 <= out2;
        end
        if ((st == RUN) && dsm_ovfl) begin
          ovfl_count <= sat_inc(ovfl_count);
        end
      end
      if ((st == RUN) && frame_tick && fifo_empty) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dsm_dem_ctrl.sv
// Bench for dsm_dem_ctrl: directed vector table, hand-written recovery/backpressure sequences, random run vs. reference model.
module tb_dsm_dem_ctrl;

  localparam int FL  = 8;
  localparam int FD  = 4;
  localparam int CLR = 4;
  localparam int MF  = 8;

  logic        mclk512 = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [23:0] s_left = '0;
  logic [23:0] s_right = '0;
  logic        cfg_exchange_lr = 1'b0;
  logic        cfg_dither_off = 1'b0;
  logic [1:0]  cfg_dem_count = '0;
  logic        dsm_ovfl = 1'b0;
  logic [23:0] dsm_chan1;
  logic [23:0] dsm_chan2;
  logic        dsm_clr;
  logic        dsmditheroff;
  logic [1:0]  dem_count;
  logic        frame_tick;
  logic        underrun;
  logic        underrun_clr = 1'b0;
  logic [7:0]  ovfl_count;
  logic [1:0]  state;

  dsm_dem_ctrl #(
    .FRAME_LEN(FL), .FIFO_DEPTH(FD), .CLR_CYCLES(CLR), .MUTE_FRAMES(MF)
  ) dut (
    .mclk512(mclk512), .reset(reset), .enable(enable),
    .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
    .cfg_exchange_lr(cfg_exchange_lr), .cfg_dither_off(cfg_dither_off),
    .cfg_dem_count(cfg_dem_count), .dsm_ovfl(dsm_ovfl),
    .dsm_chan1(dsm_chan1), .dsm_chan2(dsm_chan2), .dsm_clr(dsm_clr),
    .dsmditheroff(dsmditheroff), .dem_count(dem_count), .frame_tick(frame_tick),
    .underrun(underrun), .underrun_clr(underrun_clr), .ovfl_count(ovfl_count),
    .state(state)
  );

  always #5 mclk512 = ~mclk512;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge mclk512);
    #1;
  endtask

  task automatic wait_tick(input string name);
    int i;
    i = 0;
    while (!frame_tick && i < 4 * FL) begin
      step();
      i++;
    end
    if (!frame_tick) chk(name, {63'd0, frame_tick}, 64'd1);
  endtask

  // Directed vector table: inputs held for n cycles, then outputs compared.
  typedef struct {
    int          n;
    logic        en, v, x, uc;
    logic [23:0] l, r;
    logic [1:0]  e_st;
    logic [23:0] e_c1, e_c2;
    logic        e_tick, e_und;
  } vec_t;
  vec_t tbl[11];

  // Reference model: frame position, remaining clear cycles / mute ticks, and a sample queue.
  logic        m_on;
  int          m_pos, m_clear_left, m_mute_left, m_ov;
  logic [47:0] m_q[$];
  logic [23:0] m_c1, m_c2;
  logic        m_und, m_dith;
  logic [1:0]  m_dem;

  function automatic void m_reset();
    m_on = 1'b0; m_pos = 0; m_clear_left = 0; m_mute_left = 0; m_ov = 0;
    m_q.delete(); m_c1 = '0; m_c2 = '0; m_und = 1'b0; m_dith = 1'b0; m_dem = '0;
  endfunction

  function automatic int m_phase();
    if (!m_on) return 0;
    if (m_clear_left > 0) return 2;
    if (m_mute_left > 0) return 3;
    return 1;
  endfunction

  function automatic void m_step();
    int          ph;
    logic        tick, ready, push, was_empty, popped;
    logic [47:0] head;
    ph        = m_phase();
    tick      = m_on && (m_pos == FL - 1);
    ready     = m_on && (m_q.size() < FD);
    push      = s_valid && ready;
    was_empty = (m_q.size() == 0);
    popped    = 1'b0;
    head      = '0;
    if (ph == 1 && tick && was_empty) m_und = 1'b1;
    else if (underrun_clr) m_und = 1'b0;
    if (!enable) begin
      m_on = 1'b0; m_q.delete(); m_pos = 0; m_clear_left = 0; m_mute_left = 0;
      m_c1 = '0; m_c2 = '0; m_dem = '0; m_dith = 1'b0;
    end else if (!m_on) begin
      m_on = 1'b1;
    end else begin
      if (tick) begin
        m_dem = cfg_dem_count;
        m_dith = cfg_dither_off;
        if (!was_empty) begin
          head = m_q.pop_front();
          popped = 1'b1;
        end
      end
      case (ph)
        1: begin
          if (dsm_ovfl) begin
            m_c1 = '0; m_c2 = '0; m_clear_left = CLR;
            if (m_ov < 255) m_ov++;
          end else if (popped) begin
            m_c1 = cfg_exchange_lr ? head[23:0] : head[47:24];
            m_c2 = cfg_exchange_lr ? head[47:24] : head[23:0];
          end
        end
        2: begin
          m_clear_left--;
          if (m_clear_left == 0) m_mute_left = MF;
        end
        default: if (tick) m_mute_left--;
      endcase
      m_pos = (m_pos + 1) % FL;
      if (push) m_q.push_back({s_left, s_right});
    end
  endfunction

  initial begin
    int          n_clr, ticks, i;
    logic        zero_ok;
    logic [23:0] first_l, first_r;

    tbl[0]  = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 2'd1, 24'h000000, 24'h000000, 1'b0, 1'b0};
    tbl[1]  = '{1,  1'b1, 1'b1, 1'b0, 1'b0, 24'h000001, 24'hFFFFFF, 2'd1, 24'h000000, 24'h000000, 1'b0, 1'b0};
    tbl[2]  = '{6,  1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 2'd1, 24'h000000, 24'h000000, 1'b1, 1'b0};
    tbl[3]  = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 2'd1, 24'h000001, 24'hFFFFFF, 1'b0, 1'b0};
    tbl[4]  = '{1,  1'b1, 1'b1, 1'b0, 1'b0, 24'h000001, 24'hFFFFFF, 2'd1, 24'h000001, 24'hFFFFFF, 1'b0, 1'b0};
    tbl[5]  = '{6,  1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 2'd1, 24'h000001, 24'hFFFFFF, 1'b1, 1'b0};
    tbl[6]  = '{1,  1'b1, 1'b0, 1'b1, 1'b0, 24'h0, 24'h0, 2'd1, 24'hFFFFFF, 24'h000001, 1'b0, 1'b0};
    tbl[7]  = '{7,  1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 2'd1, 24'hFFFFFF, 24'h000001, 1'b1, 1'b0};
    tbl[8]  = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 2'd1, 24'hFFFFFF, 24'h000001, 1'b0, 1'b1};
    tbl[9]  = '{8,  1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 2'd1, 24'hFFFFFF, 24'h000001, 1'b0, 1'b1};
    tbl[10] = '{1,  1'b1, 1'b0, 1'b0, 1'b1, 24'h0, 24'h0, 2'd1, 24'hFFFFFF, 24'h000001, 1'b0, 1'b0};

    step(); step();
    chk("rst_state", state, 0);          chk("rst_clr", dsm_clr, 1);
    chk("rst_ready", s_ready, 0);        chk("rst_tick", frame_tick, 0);
    chk("rst_underrun", underrun, 0);    chk("rst_ovfl_count", ovfl_count, 0);
    chk("rst_chan1", dsm_chan1, 0);      chk("rst_chan2", dsm_chan2, 0);
    chk("rst_dem", dem_count, 0);        chk("rst_dither", dsmditheroff, 0);
    reset = 1'b0;

    for (int r = 0; r < 11; r++) begin
      enable = tbl[r].en; s_valid = tbl[r].v; cfg_exchange_lr = tbl[r].x;
      underrun_clr = tbl[r].uc; s_left = tbl[r].l; s_right = tbl[r].r;
      for (int k = 0; k < tbl[r].n; k++) step();
      chk($sformatf("vec%0d_state", r), state, tbl[r].e_st);
      chk($sformatf("vec%0d_clr", r), dsm_clr, 0);
      chk($sformatf("vec%0d_chan1", r), dsm_chan1, tbl[r].e_c1);
      chk($sformatf("vec%0d_chan2", r), dsm_chan2, tbl[r].e_c2);
      chk($sformatf("vec%0d_tick", r), frame_tick, tbl[r].e_tick);
      chk($sformatf("vec%0d_underrun", r), underrun, tbl[r].e_und);
    end
    s_valid = 1'b0; underrun_clr = 1'b0; cfg_exchange_lr = 1'b0;

    // Overflow recovery: CLEAR length, mute length, ovfl ignored while muted.
    dsm_ovfl = 1'b1;
    step();
    dsm_ovfl = 1'b0;
    chk("ovf_state", state, 2);  chk("ovf_clr", dsm_clr, 1);
    chk("ovf_chan1", dsm_chan1, 0); chk("ovf_count", ovfl_count, 1);
    n_clr = 1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (!dsm_clr) break;
      n_clr++;
    end
    chk("clr_cycles", n_clr, CLR);
    chk("mute_state", state, 3);
    ticks = 0; zero_ok = 1'b1; i = 0;
    while (state == 2'd3 && i < 200) begin
      if (frame_tick) ticks++;
      if (dsm_chan1 != 0 || dsm_chan2 != 0) zero_ok = 1'b0;
      dsm_ovfl = (i == 2);
      step();
      i++;
    end
    dsm_ovfl = 1'b0;
    chk("mute_exit_state", state, 1);
    chk("mute_ticks", ticks, MF);
    chk("mute_zero", zero_ok, 1);
    chk("mute_ovfl_ignored", ovfl_count, 1);

    // Backpressure: fill FIFO, s_ready returns after the next tick.
    wait_tick("fill_sync");
    step();
    first_l = 24'h5A0001; first_r = 24'hA50002;
    for (int k = 0; k < FD; k++) begin
      s_valid = 1'b1;
      s_left = first_l + 24'(k); s_right = first_r + 24'(k);
      step();
    end
    s_valid = 1'b0;
    chk("full_ready", s_ready, 0);
    wait_tick("full_tick");
    chk("full_ready_at_tick", s_ready, 0);
    step();
    chk("ready_after_tick", s_ready, 1);
    chk("fill_pop_chan1", dsm_chan1, first_l);
    chk("fill_pop_chan2", dsm_chan2, first_r);

    // Config applied only at frame boundary.
    step(); step();
    cfg_dem_count = 2'b11; cfg_dither_off = 1'b1;
    step();
    chk("dem_midframe", dem_count, 0);
    wait_tick("dem_tick");
    chk("dem_at_tick", dem_count, 0);
    chk("dither_at_tick", dsmditheroff, 0);
    step();
    chk("dem_after_tick", dem_count, 3);
    chk("dither_after_tick", dsmditheroff, 1);

    // enable=0 mid-frame flushes the FIFO.
    step(); step(); step();
    enable = 1'b0;
    step();
    chk("dis_state", state, 0); chk("dis_clr", dsm_clr, 1);
    chk("dis_ready", s_ready, 0); chk("dis_chan1", dsm_chan1, 0);
    step();
    chk("dis_tick", frame_tick, 0);
    enable = 1'b1; underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    chk("reen_state", state, 1);
    chk("reen_underrun", underrun, 0);
    wait_tick("flush_tick");
    step();
    chk("flushed_underrun", underrun, 1);

    // Reset in the middle of recovery.
    dsm_ovfl = 1'b1;
    step();
    dsm_ovfl = 1'b0;
    step();
    chk("pre_rst_state", state, 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_state", state, 0);   chk("mrst_clr", dsm_clr, 1);
    chk("mrst_ovfl", ovfl_count, 0); chk("mrst_dem", dem_count, 0);
    chk("mrst_underrun", underrun, 0); chk("mrst_ready", s_ready, 0);
    chk("mrst_chan2", dsm_chan2, 0);

    // Random run against the reference model.
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      enable          = ($urandom_range(0, 299) != 0);
      s_valid         = ($urandom_range(0, 15) < (((c / 400) % 2 == 1) ? 1 : 8));
      s_left          = 24'($urandom);
      s_right         = 24'($urandom);
      cfg_exchange_lr = 1'($urandom_range(0, 1));
      cfg_dither_off  = 1'($urandom_range(0, 1));
      cfg_dem_count   = 2'($urandom_range(0, 3));
      dsm_ovfl        = ($urandom_range(0, 99) == 0);
      underrun_clr    = ($urandom_range(0, 15) == 0);
      m_step();
      step();
      chk($sformatf("rand%0d_ctrl", c),
          {state, dsm_clr, s_ready, frame_tick, underrun, ovfl_count, dem_count, dsmditheroff},
          {2'(m_phase()), (!m_on || m_clear_left > 0), (m_on && m_q.size() < FD),
           (m_on && m_pos == FL - 1), m_und, 8'(m_ov), m_dem, m_dith});
      chk($sformatf("rand%0d_chan", c), {dsm_chan1, dsm_chan2}, {m_c1, m_c2});
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/dsm_dem_ctrl.md
Name: dsm_dem_ctrl

Overview:
- Sample scheduler and supervisor for the dual-channel sigma-delta modulator with DEM (dsm_dem_top).
- Accepts stereo 24-bit PCM over a valid/ready stream and buffers it in a small FIFO.
- Presents one sample pair to dsm_chan1/dsm_chan2 per frame, and applies configuration only at frame boundaries.
- Recovers from modulator overflow by pulsing dsm_clr, then muting for a set number of frames.

Parameters:
- FRAME_LEN, 512: mclk512 cycles per sample frame; must be ≥4.
- FIFO_DEPTH, 4: input FIFO entries; power of two, ≥2.
- CLR_CYCLES, 4: cycles dsm_clr is held during overflow recovery; ≥1.
- MUTE_FRAMES, 8: frames of zero input after CLEAR; ≥1.

Ports:
- mclk512  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run request; 0 forces IDLE.
- s_valid  in  1  input sample valid.
- s_ready  out  1  FIFO can accept.
- s_left  in  24  left PCM, two's complement.
- s_right  in  24  right PCM, two's complement.
- cfg_exchange_lr  in  1  swap channels.
- cfg_dither_off  in  1  dither disable request.
- cfg_dem_count  in  2  DEM mode request.
- dsm_ovfl  in  1  modulator overflow flag.
- dsm_chan1  out  24  modulator channel 1 input.
- dsm_chan2  out  24  modulator channel 2 input.
- dsm_clr  out  1  modulator clear.
- dsmditheroff  out  1  applied dither-off.
- dem_count  out  2  applied DEM mode.
- frame_tick  out  1  1-cycle pulse on the last cycle of each frame.
- underrun  out  1  sticky: FIFO empty at a RUN tick.
- underrun_clr  in  1  clears underrun.
- ovfl_count  out  8  saturating count of overflow events.
- state  out  2  current FSM state.

Behaviour:
- Reset values:
  - state=IDLE; frame counter=0; FIFO empty.
  - dsm_chan1/2=0; dsm_clr=1; dsmditheroff=0; dem_count=0.
  - s_ready=0; frame_tick=0; underrun=0; ovfl_count=0.
- Frame counter:
  - Held at 0 in IDLE; otherwise counts 0..FRAME_LEN-1 and wraps.
  - frame_tick=1 when count==FRAME_LEN-1, in any state except IDLE.
- FIFO:
  - s_ready = !full && state!=IDLE.
  - A push occurs on s_valid && s_ready.
  - A pop happens only on frame_tick. A push and pop in the same cycle are both honoured.
  - No bypass: an empty FIFO at a tick counts as empty even if a push occurs that cycle.
  - The FIFO is flushed on entry to IDLE.
- States: IDLE=0, RUN=1, CLEAR=2, MUTE=3.
  - IDLE: dsm_clr=1, outputs 0. When enable=1, go to RUN next cycle with counter=0 and dsm_clr=0.
  - RUN, frame_tick with FIFO non-empty:
    - Pop the FIFO.
    - dsm_chan1 = exchange ? right : left; dsm_chan2 = the other channel.
    - Outputs are registered, so new values are visible the cycle after the tick.
  - RUN, frame_tick with FIFO empty: hold the previous dsm_chan values and set underrun.
  - RUN, dsm_ovfl=1: next cycle go to CLEAR, increment ovfl_count (saturating at 255), set dsm_chan1/2=0.
  - CLEAR: dsm_clr=1 for exactly CLR_CYCLES cycles, then go to MUTE. dsm_ovfl is ignored.
  - MUTE:
    - dsm_chan outputs are 0.
    - The FIFO still pops and discards at each tick, keeping the stream rate.
    - Empty ticks do not set underrun.
    - After MUTE_FRAMES ticks, go to RUN. dsm_ovfl is ignored.
- enable=0 in any state: IDLE next cycle. This takes priority over dsm_ovfl.
- reset mid-frame or mid-recovery: every register returns to its reset value on the next edge.
- Configuration:
  - cfg_dither_off and cfg_dem_count are sampled into dsmditheroff/dem_count only on frame_tick (any non-IDLE state), so they never change mid-frame.
  - cfg_exchange_lr is sampled at pop.
- underrun: set takes priority over underrun_clr in the same cycle.

Optional Feature:
- Macro: DSM_DEM_SOFTSTART_EN.
- Defined:
  - On the MUTE→RUN transition a 3-bit shift register is loaded with 7.
  - Each RUN output sample is arithmetically right-shifted by that value.
  - The shift decrements by 1 per popped sample until 0.
  - Overflow re-entry reloads it on the next MUTE→RUN transition.
- Not defined: samples pass unshifted; no shift register exists.

Decomposition:
- Package dsm_dem_ctrl_pkg: state encoding (IDLE/RUN/CLEAR/MUTE), PCM_W=24, DEM_W=2, OVFL_CNT_W=8.
- One sub-module, dsm_dem_ctrl_fifo:
  - Synchronous FIFO, 48-bit entries holding {left,right}.
  - Signals: push, pop, full, empty, flush.

Test Plan:
- FRAME_LEN=8, enable=1, push L=0x000001 R=0xFFFFFF before the first tick → dsm_chan1=0x000001 and dsm_chan2=0xFFFFFF from cycle 8; underrun=0.
- Same stimulus with cfg_exchange_lr=1 → dsm_chan1=0xFFFFFF, dsm_chan2=0x000001.
- No pushes across two ticks after one sample → dsm_chan holds the last sample; underrun=1 until underrun_clr is pulsed.
- dsm_ovfl pulse in RUN → dsm_clr high for 4 cycles, then zeros for 8 ticks, then RUN; ovfl_count=1; a second dsm_ovfl during MUTE leaves the count at 1.
- Fill the FIFO to 4 entries → s_ready=0; it returns to 1 the cycle after the next tick.
- cfg_dem_count changed mid-frame to 2'b11 → dem_count changes only the cycle after frame_tick. enable=0 mid-frame → IDLE, dsm_clr=1, FIFO empty.
